nn_argmax_core: RTL and testbench
=================================

NN_ARGMAX_CORE -- requirements
Module: nn_argmax_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of signed activation and weight operands.
REQ-002 SHALL have parameter N_IN, default 16: operand pairs per class (dot-product length), 2..256.
REQ-003 SHALL have parameter N_CLASS, default 10: number of classes, 2..16.
REQ-004 SHALL have parameter ACC_W, default 24: signed accumulator/score width, at least 2*DATA_W.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin an inference.
REQ-008 SHALL have port in_valid, input, 1: x_data/w_data valid.
REQ-009 SHALL have port in_ready, output, 1: core accepts an operand pair this cycle.
REQ-010 SHALL have port x_data, input, DATA_W: signed activation.
REQ-011 SHALL have port w_data, input, DATA_W: signed weight.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port class_idx, output, 4: winning class index.
REQ-015 SHALL have port class_score, output, ACC_W: winning signed score.
REQ-016 SHALL have port sat, output, 1: a saturation occurred during the inference.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port segments, output, 7: registered 7-segment encoding {g,f,e,d,c,b,a} of class_idx, active-high.

Function
REQ-019 SHALL implement four states: IDLE, ACCUM, COMPARE, DONE.
REQ-020 SHALL, in IDLE, on start=1: clear acc, pair counter, class counter and sat, set best_idx=0, and enter ACCUM.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL drive in_ready=1 only in ACCUM; a transfer occurs when in_valid and in_ready are both 1.
REQ-023 SHALL, on each transfer, add the full-precision signed product x_data*w_data to acc, clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and set sat on any clamp.
REQ-024 SHALL operate the operand stream class-major: N_IN pairs for class 0, then N_IN for class 1, and so on.
REQ-025 SHALL enter COMPARE on the transfer that has pair counter = N_IN-1; in_valid gaps leave state and counters unchanged.
REQ-026 SHALL, in COMPARE (exactly one cycle): if class counter = 0 or acc > best, load best=acc and best_idx=class counter (ties keep the lower index).
REQ-027 SHALL leave COMPARE to DONE if class counter = N_CLASS-1, otherwise increment the class counter, clear acc and the pair counter, and return to ACCUM.
REQ-028 SHALL, in DONE: assert out_valid, present class_idx=best_idx and class_score=best, hold both stable until out_ready=1, then return to IDLE with out_valid low on the next cycle.
REQ-029 SHALL meet latency: out_valid rises on the second rising edge after the final operand transfer.
REQ-030 SHALL update segments from class_idx on each entry to DONE; it holds the last result otherwise; encoding is hex 0-F (0=0x3F, 1=0x06, 2=0x5B, ... F=0x71).
REQ-031 SHALL hold class_idx, class_score and sat at their DONE values until the next start is accepted.

Reset
REQ-032 SHALL, on rst_n=0 at any time including mid-inference: go to IDLE and set in_ready=0, out_valid=0, busy=0, sat=0, class_idx=0, class_score=0, segments=0x3F, with acc and counters zeroed.
REQ-033 SHALL leave reset synchronously to clk: the first start is honoured no earlier than the first edge with rst_n=1.

Verification (N_IN=4, N_CLASS=3, DATA_W=8, ACC_W=20 unless stated)
REQ-034 SHALL be verified by: reset asserted mid-ACCUM -> all outputs at REQ-032 values immediately, with no out_valid afterwards without a new start.
REQ-035 SHALL be verified by: x=[1,2,3,4]; w0=[1,1,1,1], w1=[2,0,0,0], w2=[0,0,0,5] -> scores 10, 2, 20; class_idx=2, class_score=20, segments=0x5B, sat=0.
REQ-036 SHALL be verified by: all three classes scoring 7 -> class_idx=0; scores -5, -3, -9 -> class_idx=1, class_score=-3.
REQ-037 SHALL be verified by: ACC_W=16, x=127 and w=127 for all pairs -> class_score=32767, sat=1.
REQ-038 SHALL be verified by: random in_valid gaps plus out_ready held low 5 cycles -> result identical to the gap-free run, out_valid held, outputs stable, start during busy ignored.

Source files
------------

// File: rtl/nn_argmax_core.sv
// nn_argmax_core: streams class-major x*w pairs, accumulates one saturating
// score per class and reports the argmax with a 7-segment view of the index.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   start                      begin an inference (sampled in IDLE only)
//   in_valid/in_ready          operand handshake for x_data/w_data
//   out_valid/out_ready        result handshake
//   class_idx/class_score/sat  winning class, its score, saturation flag
//   busy                       high in every state except IDLE
//   segments                   {g,f,e,d,c,b,a} encoding of class_idx
module nn_argmax_core #(
  parameter int DATA_W  = 8,
  parameter int N_IN    = 16,
  parameter int N_CLASS = 10,
  parameter int ACC_W   = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               class_idx,
  output logic signed [ACC_W-1:0]  class_score,
  output logic                     sat,
  output logic                     busy,
  output logic [6:0]               segments
);

  localparam int PW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PRW = 2 * DATA_W;

  localparam logic [PW-1:0] PAIR_LAST = PW'(N_IN - 1);
  localparam logic [3:0]    CLS_LAST  = 4'(N_CLASS - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] best_q;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [PW-1:0]           pair_q;
  logic [3:0]              cls_q;
  logic [3:0]              best_idx_q;
  logic [3:0]              win_idx;
  logic                    sat_q;
  logic [6:0]              seg_q;

  logic                    xfer;
  logic                    last_pair;
  logic                    last_cls;
  logic                    take_best;
  logic                    ovf_hi;
  logic                    ovf_lo;
  logic signed [PRW-1:0]   prod;
  logic [ACC_W:0]          sum;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    seg7 = 7'h00;
    case (v)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign xfer      = in_valid & in_ready;
  assign last_pair = (pair_q == PAIR_LAST);
  assign last_cls  = (cls_q == CLS_LAST);

  // One guard bit above the accumulator exposes overflow of the sum.
  assign prod   = x_data * w_data;
  assign sum    = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W+1-PRW){prod[PRW-1]}}, prod};
  assign ovf_hi = ~sum[ACC_W] & sum[ACC_W-1];
  assign ovf_lo = sum[ACC_W] & ~sum[ACC_W-1];

  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (ovf_hi) acc_nxt = ACC_MAX;
    if (ovf_lo) acc_nxt = ACC_MIN;
  end

  // Strict compare: ties keep the earlier (lower) class.
  assign take_best = (cls_q == 4'd0) || (acc_q > best_q);
  assign win_idx   = take_best ? cls_q : best_idx_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (xfer && last_pair) state_d = COMPARE;
      COMPARE: state_d = last_cls ? DONE : ACCUM;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      best_q     <= '0;
      pair_q     <= '0;
      cls_q      <= '0;
      best_idx_q <= '0;
      sat_q      <= 1'b0;
      seg_q      <= 7'h3F;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q      <= '0;
            pair_q     <= '0;
            cls_q      <= '0;
            sat_q      <= 1'b0;
            best_idx_q <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_q  <= acc_nxt;
            sat_q  <= sat_q | ovf_hi | ovf_lo;
            pair_q <= last_pair ? '0 : pair_q + PW'(1);
          end
        end
        COMPARE: begin
          if (take_best) begin
            best_q     <= acc_q;
            best_idx_q <= cls_q;
          end
          if (last_cls) begin
            seg_q <= seg7(win_idx);
          end else begin
            cls_q  <= cls_q + 4'd1;
            acc_q  <= '0;
            pair_q <= '0;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign class_idx   = best_idx_q;
  assign class_score = best_q;
  assign sat         = sat_q;
  assign segments    = seg_q;

endmodule

// File: tb/tb_nn_argmax_core.sv
// tb_nn_argmax_core: scoreboard bench for nn_argmax_core, one instance at
// ACC_W=20 and one at ACC_W=16 for the saturation case.
module tb_nn_argmax_core;

  localparam int NI  = 4;
  localparam int NC  = 3;
  localparam int DW  = 8;
  localparam int AW  = 20;
  localparam int AW2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic out_ready2 = 1'b0;
  logic signed [DW-1:0] x = '0;
  logic signed [DW-1:0] w = '0;

  logic                  in_ready, out_valid, sat, busy;
  logic [3:0]            class_idx;
  logic signed [AW-1:0]  class_score;
  logic [6:0]            segments;

  logic                  in_ready2, out_valid2, sat2, busy2;
  logic [3:0]            class_idx2;
  logic signed [AW2-1:0] class_score2;
  logic [6:0]            segments2;

  always #5 clk = ~clk;

  nn_argmax_core #(
    .DATA_W(DW), .N_IN(NI), .N_CLASS(NC), .ACC_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_data(x), .w_data(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .class_score(class_score),
    .sat(sat), .busy(busy), .segments(segments)
  );

  nn_argmax_core #(
    .DATA_W(DW), .N_IN(NI), .N_CLASS(NC), .ACC_W(AW2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(in_valid), .in_ready(in_ready2),
    .x_data(x), .w_data(w),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .class_idx(class_idx2), .class_score(class_score2),
    .sat(sat2), .busy(busy2), .segments(segments2)
  );

  typedef struct {
    int     idx;
    longint score;
    bit     sat;
  } exp_t;

  exp_t sb[$];
  logic signed [DW-1:0] xv[NC][NI];
  logic signed [DW-1:0] wv[NC][NI];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;
      3: return 7'h4F;  4: return 7'h66;  5: return 7'h6D;
      6: return 7'h7D;  7: return 7'h07;  8: return 7'h7F;
      9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  task automatic set_row(input int c,
                         input int x0, input int x1,
                         input int x2, input int x3,
                         input int w0, input int w1,
                         input int w2, input int w3);
    xv[c][0] = DW'(x0); xv[c][1] = DW'(x1);
    xv[c][2] = DW'(x2); xv[c][3] = DW'(x3);
    wv[c][0] = DW'(w0); wv[c][1] = DW'(w1);
    wv[c][2] = DW'(w2); wv[c][3] = DW'(w3);
  endtask

  task automatic basic_rows();
    for (int c = 0; c < NC; c++)
      set_row(c, 1, 2, 3, 4, 0, 0, 0, 0);
    set_row(0, 1, 2, 3, 4, 1, 1, 1, 1);
    set_row(1, 1, 2, 3, 4, 2, 0, 0, 0);
    set_row(2, 1, 2, 3, 4, 0, 0, 0, 5);
  endtask

  // Reference: per-step clamp to the accumulator range, strict argmax.
  task automatic model_push(input int aw);
    longint mx, mn, acc, best;
    int bi;
    bit s;
    exp_t e;
    mx = (longint'(1) <<< (aw - 1)) - 1;
    mn = -mx - 1;
    best = 0;
    bi = 0;
    s = 0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int p = 0; p < NI; p++) begin
        acc += longint'(int'(xv[c][p]) * int'(wv[c][p]));
        if (acc > mx) begin acc = mx; s = 1; end
        if (acc < mn) begin acc = mn; s = 1; end
      end
      if (c == 0 || acc > best) begin
        best = acc;
        bi = c;
      end
    end
    e.idx = bi;
    e.score = best;
    e.sat = s;
    sb.push_back(e);
  endtask

  // Pulse start, then stream all pairs; returns #1 after the final
  // transfer edge.  poke raises start once mid-stream (must be ignored).
  task automatic drive_run(input bit sel, input bit gaps, input bit poke);
    int cyc;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NI; p++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            x = DW'($urandom);
            w = DW'($urandom);
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b1;
        x = xv[c][p];
        w = wv[c][p];
        cyc = 0;
        while (!(sel ? in_ready2 : in_ready)) begin
          @(posedge clk); #1;
          cyc++;
          if (cyc > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: class %0d pair %0d", c, p);
            break;
          end
        end
        if (poke && c == 1 && p == 1) begin
          if (sel) start2 = 1'b1; else start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        start2 = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer: waits (bounded) for the result and compares it.
  task automatic collect(input bit sel, input string tag);
    int cyc;
    exp_t e;
    longint got_score;
    int got_idx;
    bit got_sat;
    logic [6:0] got_seg;
    cyc = 0;
    while (!(sel ? out_valid2 : out_valid)) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s out_valid_timeout", tag);
        break;
      end
    end
    got_idx   = sel ? int'(class_idx2) : int'(class_idx);
    got_score = sel ? longint'(class_score2) : longint'(class_score);
    got_sat   = sel ? sat2 : sat;
    got_seg   = sel ? segments2 : segments;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty", tag);
    end else begin
      e = sb.pop_front();
      if (got_idx !== e.idx) begin
        n_fail++;
        $display("FAIL %s class_idx: got %0d expected %0d",
                 tag, got_idx, e.idx);
      end
      n_checks++;
      if (got_score !== e.score) begin
        n_fail++;
        $display("FAIL %s class_score: got %0d expected %0d",
                 tag, got_score, e.score);
      end
      n_checks++;
      if (got_sat !== e.sat) begin
        n_fail++;
        $display("FAIL %s sat: got %0b expected %0b",
                 tag, got_sat, e.sat);
      end
      n_checks++;
      if (got_seg !== seg_ref(e.idx)) begin
        n_fail++;
        $display("FAIL %s segments: got %h expected %h",
                 tag, got_seg, seg_ref(e.idx));
      end
    end
  endtask

  task automatic release_result(input bit sel);
    if (sel) out_ready2 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, sat} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {in_ready, out_valid, busy, sat});
    end
    n_checks++;
    if (class_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got %0d expected 0", class_idx);
    end
    n_checks++;
    if (class_score !== '0) begin
      n_fail++;
      $display("FAIL reset_score: got %0d expected 0", class_score);
    end
    n_checks++;
    if (segments !== 7'h3F || segments2 !== 7'h3F) begin
      n_fail++;
      $display("FAIL reset_segments: got %h/%h expected 3f",
               segments, segments2);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    basic_rows();
    model_push(AW);
    drive_run(0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_early: got valid=%b busy=%b expected 0/1",
               out_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: got out_valid=%b expected 1", out_valid);
    end
    collect(0, "basic");
    release_result(0);
  endtask

  task automatic test_ties();
    for (int c = 0; c < NC; c++)
      set_row(c, 1, 2, 3, 4, 7, 0, 0, 0);
    model_push(AW);
    drive_run(0, 0, 0);
    collect(0, "tie");
    release_result(0);
    set_row(0, 1, 1, 1, 1, -5, 0, 0, 0);
    set_row(1, 1, 1, 1, 1, -3, 0, 0, 0);
    set_row(2, 1, 1, 1, 1, -9, 0, 0, 0);
    model_push(AW);
    drive_run(0, 0, 0);
    collect(0, "negative");
    release_result(0);
  endtask

  task automatic test_sat();
    for (int c = 0; c < NC; c++)
      set_row(c, 127, 127, 127, 127, 127, 127, 127, 127);
    model_push(AW2);
    drive_run(1, 0, 0);
    collect(1, "saturate");
    release_result(1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ci;
    logic signed [AW-1:0] cs;
    logic [6:0] sg;
    basic_rows();
    model_push(AW);
    drive_run(0, 1, 1);
    collect(0, "gaps");
    ci = class_idx;
    cs = class_score;
    sg = segments;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || class_idx !== ci ||
          class_score !== cs || segments !== sg) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b idx=%0d score=%0d expected v=1 idx=%0d score=%0d",
                 i, out_valid, class_idx, class_score, ci, cs);
      end
    end
    release_result(0);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake: got valid=%b busy=%b expected 0/0",
               out_valid, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (class_idx !== ci || class_score !== cs || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got idx=%0d score=%0d sat=%b expected idx=%0d score=%0d sat=0",
               class_idx, class_score, sat, ci, cs);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < NI; p++) begin
          xv[c][p] = DW'($urandom);
          wv[c][p] = DW'($urandom);
        end
      model_push(AW);
      drive_run(0, 1, 0);
      collect(0, $sformatf("random%0d", r));
      release_result(0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    basic_rows();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    x = 8'sd3;
    w = 8'sd4;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, sat} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b expected 0000",
               {in_ready, out_valid, busy, sat});
    end
    n_checks++;
    if (class_idx !== 4'd0 || class_score !== '0) begin
      n_fail++;
      $display("FAIL midreset_result: got idx=%0d score=%0d expected 0/0",
               class_idx, class_score);
    end
    n_checks++;
    if (segments !== 7'h3F) begin
      n_fail++;
      $display("FAIL midreset_segments: got %h expected 3f", segments);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= out_valid | busy;
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got activity=%b expected 0", seen);
    end
    model_push(AW);
    drive_run(0, 0, 0);
    collect(0, "after_reset");
    release_result(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_sat();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
